// File: rtl/mac_pkg.sv
// Shared types and default geometry for the sequential multiply-accumulate block.
package mac_pkg;

  typedef enum logic {
    ACCUM,
    DONE
  } mac_state_t;

  localparam int unsigned DefM    = 4;
  localparam int unsigned DefN    = 4;
  localparam int unsigned DefAccW = 12;
  localparam int unsigned DefLen  = 4;

  // Counter width able to hold the values 0..len inclusive.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mult_mnbit.sv
// Unsigned M x N array multiplier: one AND row per bit of b, summed by a chain of row adders.
module mult_mnbit #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 4
) (
  input  logic [M-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [M+N-1:0] o_prod
);

  logic [M+N-1:0] w_pp  [N];
  logic [M+N-1:0] w_sum [N+1];

  assign w_sum[0] = '0;

  for (genvar j = 0; j < N; j++) begin : g_row
    assign w_pp[j]      = {{N{1'b0}}, i_a & {M{i_b[j]}}} << j;
    assign w_sum[j + 1] = w_sum[j] + w_pp[j];
  end

  assign o_prod = w_sum[N];

endmodule

// File: rtl/mult_acc_seq.sv
// Registers operand pairs in front of mult_mnbit and sums LEN unsigned products per result,
// handing each dot product out over a valid/ready handshake.
module mult_acc_seq
  import mac_pkg::*;
#(
  parameter int unsigned M     = DefM,
  parameter int unsigned N     = DefN,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned LEN   = DefLen
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int unsigned CntW = cnt_width(LEN);
  localparam int unsigned PW   = M + N;
  localparam int unsigned SumW = ACC_W + 1;

  localparam logic [CntW-1:0] LenC  = CntW'(LEN);
  localparam logic [CntW-1:0] LastC = CntW'(LEN - 1);
  localparam logic [CntW-1:0] OneC  = CntW'(1);

  if (ACC_W < M + N) begin : g_bad_acc_w
    $error("mult_acc_seq: ACC_W must be at least M+N");
  end
  if (LEN < 1) begin : g_bad_len
    $error("mult_acc_seq: LEN must be at least 1");
  end

  mac_state_t      r_state, w_state_nxt;
  logic [M-1:0]    r_a, w_a_nxt;
  logic [N-1:0]    r_b, w_b_nxt;
  logic            r_p_vld, w_p_vld_nxt;
  logic [CntW-1:0] r_in_cnt, w_in_cnt_nxt;
  logic [CntW-1:0] r_acc_cnt, w_acc_cnt_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_out_valid, w_out_valid_nxt;

  logic            w_accept;
  logic [PW-1:0]   w_prod;
  logic [SumW-1:0] w_sum;

  mult_mnbit #(
    .M(M),
    .N(N)
  ) u_mult (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_prod(w_prod)
  );

  // in_cnt caps acceptance at LEN so a batch never takes more than LEN pairs.
  assign in_ready = (r_state == ACCUM) && (r_in_cnt < LenC) && !rst;
  assign w_accept = in_valid && in_ready;

  // Extra top bit captures the carry out of the accumulator for the sticky wrap flag.
  assign w_sum = {1'b0, r_acc} + SumW'(w_prod);

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_p_vld_nxt     = w_accept;
    w_in_cnt_nxt    = r_in_cnt;
    w_acc_cnt_nxt   = r_acc_cnt;
    w_acc_nxt       = r_acc;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;

    if (w_accept) begin
      w_a_nxt      = a;
      w_b_nxt      = b;
      w_in_cnt_nxt = r_in_cnt + OneC;
    end

    unique case (r_state)
      ACCUM: begin
        if (r_p_vld) begin
          w_acc_nxt     = w_sum[ACC_W-1:0];
          w_ovf_nxt     = r_ovf | w_sum[ACC_W];
          w_acc_cnt_nxt = r_acc_cnt + OneC;
          if (r_acc_cnt == LastC) begin
            w_state_nxt     = DONE;
            w_out_valid_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt     = ACCUM;
          w_out_valid_nxt = 1'b0;
          w_acc_nxt       = '0;
          w_ovf_nxt       = 1'b0;
          w_in_cnt_nxt    = '0;
          w_acc_cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_a         <= '0;
      r_b         <= '0;
      r_p_vld     <= 1'b0;
      r_in_cnt    <= '0;
      r_acc_cnt   <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_p_vld     <= w_p_vld_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_acc_cnt   <= w_acc_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mult_acc_seq.sv
// Directed bench: three instances (default, ACC_W=8, LEN=1) driven from batch tables
// and short hand-written sequences for back-pressure, mid-batch reset and single-term batches.
module tb_mult_acc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s       [3];
  logic       in_valid_s  [3];
  logic       out_ready_s [3];
  logic [3:0] a_s         [3];
  logic [3:0] b_s         [3];

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        ovf0, ovf1, ovf2;
  logic [11:0] acc0, acc2;
  logic [7:0]  acc1;

  int checks = 0;
  int errors = 0;

  mult_acc_seq #(.M(4), .N(4), .ACC_W(12), .LEN(4)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(rdy0),
    .a(a_s[0]), .b(b_s[0]), .out_valid(ov0), .out_ready(out_ready_s[0]),
    .acc_out(acc0), .ovf(ovf0)
  );

  mult_acc_seq #(.M(4), .N(4), .ACC_W(8), .LEN(4)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(rdy1),
    .a(a_s[1]), .b(b_s[1]), .out_valid(ov1), .out_ready(out_ready_s[1]),
    .acc_out(acc1), .ovf(ovf1)
  );

  mult_acc_seq #(.M(4), .N(4), .ACC_W(12), .LEN(1)) u_dut2 (
    .clk(clk), .rst(rst_s[2]), .in_valid(in_valid_s[2]), .in_ready(rdy2),
    .a(a_s[2]), .b(b_s[2]), .out_valid(ov2), .out_ready(out_ready_s[2]),
    .acc_out(acc2), .ovf(ovf2)
  );

  function automatic logic [31:0] acc_of(input int d);
    case (d)
      0:       return {20'h0, acc0};
      1:       return {24'h0, acc1};
      default: return {20'h0, acc2};
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic ov_of(input int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic ovf_of(input int d);
    case (d)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic int cnt_of(input int d);
    case (d)
      0:       return int'(u_dut0.r_in_cnt);
      1:       return int'(u_dut1.r_in_cnt);
      default: return int'(u_dut2.r_in_cnt);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds four pairs (nibble k of av/bv is pair k) with up to max_gap idle cycles between
  // them, then checks the result, its latency and the output handshake.
  task automatic run_batch(input int d, input logic [15:0] av, input logic [15:0] bv,
                           input int max_gap, input int hold, input int exp_acc,
                           input int exp_ovf, input string tag);
    int k, cyc, last, gap, max_cnt;
    bit seen, fire;
    k = 0; cyc = 0; last = 0; max_cnt = 0; seen = 1'b0;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    out_ready_s[d] = (hold == 0);
    while (!seen && cyc < 100) begin
      if (k < 4 && gap == 0) begin
        in_valid_s[d] = 1'b1;
        a_s[d] = av[k*4 +: 4];
        b_s[d] = bv[k*4 +: 4];
      end else begin
        in_valid_s[d] = 1'b0;
      end
      fire = in_valid_s[d] && rdy_of(d);
      step();
      cyc++;
      if (fire) begin
        k++;
        last = cyc;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      end else if (gap > 0) begin
        gap--;
      end
      if (cnt_of(d) > max_cnt) max_cnt = cnt_of(d);
      seen = ov_of(d);
    end
    in_valid_s[d] = 1'b0;
    chk({tag, "_out_valid_seen"}, 32'(seen), 32'd1);
    chk({tag, "_accepted"}, k, 4);
    chk({tag, "_in_cnt_bound"}, 32'(max_cnt > 4), 32'd0);
    chk({tag, "_acc"}, acc_of(d), exp_acc);
    chk({tag, "_ovf"}, 32'(ovf_of(d)), exp_ovf);
    chk({tag, "_latency"}, cyc - last, 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid_s[d] = 1'b1;
        a_s[d] = 4'd1;
        b_s[d] = 4'd1;
        step();
        chk({tag, "_hold_acc"}, acc_of(d), exp_acc);
        chk({tag, "_hold_in_ready"}, 32'(rdy_of(d)), 32'd0);
        chk({tag, "_hold_out_valid"}, 32'(ov_of(d)), 32'd1);
      end
      in_valid_s[d] = 1'b0;
      out_ready_s[d] = 1'b1;
    end
    step();
    chk({tag, "_out_valid_width"}, 32'(ov_of(d)), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(rdy_of(d)), 32'd1);
    chk({tag, "_acc_cleared"}, acc_of(d), 32'd0);
  endtask

  typedef struct {
    int          d;
    logic [15:0] av;
    logic [15:0] bv;
    int          gap;
    int          exp_acc;
    int          exp_ovf;
  } vec_t;

  typedef struct {
    logic       iv;
    logic [3:0] a;
    logic [3:0] b;
    logic       ov;
    int         acc;
    logic       rdy;
  } cyc_t;

  vec_t tbl  [7];
  cyc_t len1 [6];

  initial begin
    // 3*5 + 2*7 + 15*15 + 0*9 = 254
    tbl[0] = '{0, 16'h0F23, 16'h9F75, 0, 254, 0};
    tbl[1] = '{0, 16'h0F23, 16'h9F75, 3, 254, 0};
    tbl[2] = '{0, 16'hFFFF, 16'hFFFF, 2, 900, 0};
    tbl[3] = '{0, 16'h0000, 16'hFFFF, 0, 0, 0};
    tbl[4] = '{0, 16'h1234, 16'h4321, 1, 20, 0};
    // 900 mod 256 = 132 with wrap, then 4*2 = 8 with the flag cleared
    tbl[5] = '{1, 16'hFFFF, 16'hFFFF, 0, 132, 1};
    tbl[6] = '{1, 16'h1111, 16'h2222, 1, 8, 0};

    len1[0] = '{1'b1, 4'd7, 4'd3, 1'b0, 0,  1'b0};
    len1[1] = '{1'b1, 4'd5, 4'd5, 1'b1, 21, 1'b0};
    len1[2] = '{1'b1, 4'd5, 4'd5, 1'b0, 0,  1'b1};
    len1[3] = '{1'b1, 4'd5, 4'd5, 1'b0, 0,  1'b0};
    len1[4] = '{1'b0, 4'd0, 4'd0, 1'b1, 25, 1'b0};
    len1[5] = '{1'b0, 4'd0, 4'd0, 1'b0, 0,  1'b1};

    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1;
      in_valid_s[d] = 1'b0;
      out_ready_s[d] = 1'b1;
      a_s[d] = 4'd0;
      b_s[d] = 4'd0;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_in_ready_%0d", d), 32'(rdy_of(d)), 32'd0);
      chk($sformatf("reset_out_valid_%0d", d), 32'(ov_of(d)), 32'd0);
      chk($sformatf("reset_acc_%0d", d), acc_of(d), 32'd0);
      chk($sformatf("reset_ovf_%0d", d), 32'(ovf_of(d)), 32'd0);
    end
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_reset_in_ready_%0d", d), 32'(rdy_of(d)), 32'd1);
    end
    step();

    for (int i = 0; i < 7; i++) begin
      run_batch(tbl[i].d, tbl[i].av, tbl[i].bv, tbl[i].gap, 0, tbl[i].exp_acc,
                tbl[i].exp_ovf, $sformatf("b%0d", i));
    end

    // Back-pressure: result held for 10 cycles, then a batch of four (1,1).
    run_batch(0, 16'h0F23, 16'h9F75, 0, 10, 254, 0, "hold");
    run_batch(0, 16'h1111, 16'h1111, 0, 0, 4, 0, "after_hold");

    // Reset after two accepted (4,4) pairs.
    in_valid_s[0] = 1'b1;
    a_s[0] = 4'd4;
    b_s[0] = 4'd4;
    step();
    step();
    in_valid_s[0] = 1'b0;
    chk("mid_partial_acc", acc_of(0), 32'd16);
    rst_s[0] = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(rdy_of(0)), 32'd0);
    step();
    rst_s[0] = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov_of(0)), 32'd0);
    chk("mid_rst_acc", acc_of(0), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_of(0)), 32'd0);
    chk("mid_rst_in_ready_after", 32'(rdy_of(0)), 32'd1);
    run_batch(0, 16'h4444, 16'h4444, 0, 0, 64, 0, "post_mid_rst");

    // LEN=1: (7,3) then (5,5) with in_valid held; each result one cycle wide.
    out_ready_s[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid_s[2] = len1[i].iv;
      a_s[2] = len1[i].a;
      b_s[2] = len1[i].b;
      step();
      chk($sformatf("len1_out_valid_c%0d", i), 32'(ov_of(2)), 32'(len1[i].ov));
      chk($sformatf("len1_acc_c%0d", i), acc_of(2), len1[i].acc);
      chk($sformatf("len1_in_ready_c%0d", i), 32'(rdy_of(2)), 32'(len1[i].rdy));
    end
    in_valid_s[2] = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
